// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared state encoding and sizing constants for the PWM capture block
package pwm_capture_pkg;
  localparam int CAP_WIDTH = 16;
  localparam logic [CAP_WIDTH-1:0] CAP_CNT_MAX = '1;
  localparam logic [1:0] CAP_IDLE = 2'd0;
  localparam logic [1:0] CAP_ARMED = 2'd1;
  localparam logic [1:0] CAP_MEASURE = 2'd2;
endpackage

// File: rtl/project_pwm_capture_edge.sv
// project_pwm_capture_edge: synchronizes the PWM pin, applies inversion and detects edges
//   i_clk/i_reset_n : clock, async active-low reset
//   i_pwm           : asynchronous pin
//   i_invert        : invert the synchronized level
//   o_s             : synchronized (optionally inverted) level
//   o_rise/o_fall   : single-cycle edge strobes of o_s
module project_pwm_capture_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_pwm,
  input  logic i_invert,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic r_s_d;
  logic w_s;
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= '0;
      r_s_d <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pwm};
      r_s_d <= w_s;
    end
  end
  // inversion sits after the synchronizer, so toggling it looks like a pin edge
  assign w_s = r_sync[SYNC_STAGES-1] ^ i_invert;
  assign o_s = w_s;
  assign o_rise = w_s & ~r_s_d;
  assign o_fall = ~w_s & r_s_d;
endmodule

// File: rtl/project_pwm_capture.sv
// project_pwm_capture: measures period and active time of an external PWM waveform
//   i_clk/i_reset_n : clock, async active-low reset
//   i_en            : capture enable; low forces IDLE
//   i_invert        : measure low time instead of high time
//   i_clear         : clears the sticky overflow flag
//   i_pwm           : asynchronous PWM input
//   o_period/o_high : last measured period and active time in clock cycles
//   o_valid         : one-cycle strobe when results update
//   o_overflow      : sticky, counter saturated without a rising edge
//   o_busy          : high while measuring
module project_pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int WIDTH = CAP_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_en,
  input  logic             i_invert,
  input  logic             i_clear,
  input  logic             i_pwm,
  output logic [WIDTH-1:0] o_period,
  output logic [WIDTH-1:0] o_high,
  output logic             o_valid,
  output logic             o_overflow,
  output logic             o_busy
);
  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  logic [1:0] r_state;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_high_latch;
  logic [WIDTH-1:0] r_period;
  logic [WIDTH-1:0] r_high;
  logic r_valid;
  logic r_overflow;
  logic w_s;
  logic w_rise;
  logic w_fall;
  logic w_measure;
  logic w_ovf_set;
  project_pwm_capture_edge #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_pwm    (i_pwm),
    .i_invert (i_invert),
    .o_s      (w_s),
    .o_rise   (w_rise),
    .o_fall   (w_fall)
  );
  assign w_measure = (r_state == CAP_MEASURE);
  // saturation with no closing edge: 0%/100% duty or a stopped source
  assign w_ovf_set = i_en & w_measure & ~w_rise & (r_cnt == CNT_MAX);
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= CAP_IDLE;
      r_cnt <= '0;
      r_high_latch <= '0;
      r_period <= '0;
      r_high <= '0;
      r_valid <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_overflow <= w_ovf_set | (r_overflow & ~i_clear);
      if (!i_en) begin
        r_state <= CAP_IDLE;
        r_cnt <= '0;
        r_high_latch <= '0;
      end else if (r_state == CAP_IDLE) begin
        r_state <= CAP_ARMED;
      end else if (!w_measure) begin
        if (w_rise) begin
          r_state <= CAP_MEASURE;
          r_cnt <= WIDTH'(1);
          r_high_latch <= '0;
        end
      end else if (w_rise) begin
        r_period <= r_cnt;
        r_high <= r_high_latch;
        r_valid <= 1'b1;
        r_cnt <= WIDTH'(1);
        r_high_latch <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_state <= CAP_ARMED;
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
        if (w_fall) r_high_latch <= r_cnt;
      end
    end
  end
  assign o_period = r_period;
  assign o_high = r_high;
  assign o_valid = r_valid;
  assign o_overflow = r_overflow;
  assign o_busy = w_measure;
  logic w_unused;
  assign w_unused = w_s;
endmodule
